// File: rtl/dac_stream_ctrl.sv
// Per-channel sample FIFO: registered level, combinational head read, flush empties it.
// Latency: push visible in level next cycle; head sample is readable in the same cycle as a pop.
// Backpressure: full comes from registered level, so a push into a full FIFO is dropped even if a pop happens that cycle.
module dac_sample_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          full
);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop && (level != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// Multi-channel DAC sample engine: per-channel FIFOs popped together on a programmable tick.
// Latency: tick in cycle t updates dac_data, fifo_level and underflow at t+1.
// Backpressure: wr_ready per channel drops when its FIFO holds C_FIFO_DEPTH samples; writes then are dropped.
module dac_stream_ctrl #(
    parameter int C_NUM_CH     = 2,
    parameter int C_DATA_WIDTH = 10,
    parameter int C_FIFO_DEPTH = 16,
    parameter int C_DIV_WIDTH  = 16
) (
    input  logic                                          Bus2IP_Clk,
    input  logic                                          Bus2IP_Reset,
    input  logic [C_NUM_CH-1:0]                           wr_valid,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]              wr_data,
    output logic [C_NUM_CH-1:0]                           wr_ready,
    input  logic                                          ctrl_enable,
    input  logic [C_DIV_WIDTH-1:0]                        ctrl_div,
    input  logic                                          ctrl_twos,
    input  logic                                          ctrl_uf_mid,
    input  logic                                          ctrl_flush,
    input  logic                                          ctrl_clr_status,
    output logic [C_NUM_CH*($clog2(C_FIFO_DEPTH)+1)-1:0]  fifo_level,
    output logic [C_NUM_CH-1:0]                           underflow,
    output logic [C_NUM_CH*C_DATA_WIDTH-1:0]              dac_data,
    output logic                                          dac_dclk,
    output logic                                          dac_pwrdn
);
    localparam int W  = C_DATA_WIDTH;
    localparam int LW = $clog2(C_FIFO_DEPTH) + 1;
    localparam logic [W-1:0] MIDSCALE = {1'b1, {(W-1){1'b0}}};

    logic [C_DIV_WIDTH-1:0] div_eff;
    logic [C_DIV_WIDTH-1:0] cnt_q;
    logic                   tick;
    logic                   pop_en;

    // A divider of 0 behaves as 1 so the period never collapses below 2 clocks.
    assign div_eff = (ctrl_div == '0) ? C_DIV_WIDTH'(1) : ctrl_div;
    assign tick    = ctrl_enable && (cnt_q == div_eff);
    assign pop_en  = tick && !ctrl_flush;

    // cnt >= D also catches a divider lowered below the running count: wrap without a tick.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            cnt_q     <= '0;
            dac_dclk  <= 1'b0;
            dac_pwrdn <= 1'b1;
        end else begin
            if (!ctrl_enable || cnt_q >= div_eff) cnt_q <= '0;
            else                                  cnt_q <= cnt_q + C_DIV_WIDTH'(1);
            dac_dclk  <= ctrl_enable && (cnt_q > (div_eff >> 1));
            dac_pwrdn <= ~ctrl_enable;
        end
    end

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        logic [W-1:0]  head_dat;
        logic [W-1:0]  conv_dat;
        logic [W-1:0]  data_q;
        logic [LW-1:0] lvl;
        logic          full;
        logic          empty;
        logic          uf_q;

        dac_sample_fifo #(
            .W     (W),
            .DEPTH (C_FIFO_DEPTH)
        ) u_fifo (
            .clk      (Bus2IP_Clk),
            .rst      (Bus2IP_Reset),
            .flush    (ctrl_flush),
            .push_vld (wr_valid[g]),
            .push_dat (wr_data[g*W +: W]),
            .pop      (pop_en),
            .head_dat (head_dat),
            .level    (lvl),
            .full     (full)
        );

        assign empty    = (lvl == '0);
        assign conv_dat = ctrl_twos ? {~head_dat[W-1], head_dat[W-2:0]} : head_dat;

        always_ff @(posedge Bus2IP_Clk) begin
            if (Bus2IP_Reset) begin
                data_q <= MIDSCALE;
                uf_q   <= 1'b0;
            end else begin
                if (pop_en) begin
                    if (!empty)          data_q <= conv_dat;
                    else if (ctrl_uf_mid) data_q <= MIDSCALE;
                end
                // A fresh underflow beats a same-cycle clear.
                if (pop_en && empty)     uf_q <= 1'b1;
                else if (ctrl_clr_status) uf_q <= 1'b0;
            end
        end

        assign wr_ready[g]             = ~full;
        assign fifo_level[g*LW +: LW]  = lvl;
        assign dac_data[g*W +: W]      = data_q;
        assign underflow[g]            = uf_q;
    end
endmodule
